// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing req/ack fetches and presenting instructions under valid/ready
module instr_fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [31:0]         imem_rdata_i,
  output logic [31:0]         instr_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_plus4_o,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                misalign_o,
  output logic [31:0]         instr_count_o
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, ipc_q, ipc_d, ip4_q, ip4_d;
  logic [31:0]         instr_q, instr_d, instr_count_q, instr_count_d;
  logic                misalign_q, misalign_d;
  // next-state: IDLE swallows stale acks, FETCH waits for ack, VALID waits for accept
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ipc_d         = ipc_q;
    ip4_d         = ip4_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;
    misalign_d    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (imem_ack_i) begin
        state_d = VALID;
        instr_d = imem_rdata_i;
        ipc_d   = pc_q;
        ip4_d   = pc_q + PC_WIDTH'(4);
      end
      VALID: if (instr_ready_i) begin
        state_d       = FETCH;
        pc_d          = redirect_valid_i ? {redirect_pc_i[PC_WIDTH-1:2], 2'b00} : pc_q + PC_WIDTH'(4);
        instr_count_d = instr_count_q + 32'd1;
        misalign_d    = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      ipc_q         <= RESET_PC;
      ip4_q         <= RESET_PC + PC_WIDTH'(4);
      instr_q       <= '0;
      instr_count_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ipc_q         <= ipc_d;
      ip4_q         <= ip4_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
      misalign_q    <= misalign_d;
    end
  end
  assign imem_req_o    = state_q == FETCH;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = state_q == VALID;
  assign instr_o       = instr_q;
  assign pc_o          = ipc_q;
  assign pc_plus4_o    = ip4_q;
  assign misalign_o    = misalign_q;
  assign instr_count_o = instr_count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks against a transaction-level fetch model
module tb_instr_fetch_unit;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        imem_req_o, imem_ack_i = 1'b0, instr_valid_o, instr_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0, misalign_o;
  logic [31:0] imem_addr_o, imem_rdata_i = '0, instr_o, pc_o, pc_plus4_o, redirect_pc_i = '0, instr_count_o;
  int          tests = 0, errors = 0;
  bit          m_idle, m_have, m_mis;
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .misalign_o(misalign_o), .instr_count_o(instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_have = 0; m_mis = 0;
    m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc_plus4_o, 4);
    chk("rst_mis", 32'(misalign_o), 0);
    chk("rst_cnt", instr_count_o, 0);
  endtask

  // called just after a falling edge; applies inputs, checks, advances the model one clock
  task automatic step(input bit ack, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit exp_req;
    exp_req = !m_idle && !m_have;
    imem_ack_i = ack; instr_ready_i = rdy; redirect_valid_i = rv; redirect_pc_i = rpc;
    imem_rdata_i = (ack && exp_req) ? mem(m_pc) : $urandom();
    #1;
    chk("req", 32'(imem_req_o), 32'(exp_req));
    chk("valid", 32'(instr_valid_o), 32'(m_have));
    chk("cnt", instr_count_o, m_cnt);
    chk("mis", 32'(misalign_o), 32'(m_mis));
    if (exp_req) chk("addr", imem_addr_o, m_pc);
    if (m_have) begin
      chk("instr", instr_o, m_instr);
      chk("pc", pc_o, m_ipc);
      chk("pc4", pc_plus4_o, m_ipc + 32'd4);
    end
    @(posedge clk_i);
    m_mis = 0;
    if (m_idle) m_idle = 0;
    else if (!m_have) begin
      if (ack) begin m_have = 1; m_instr = mem(m_pc); m_ipc = m_pc; end
    end else if (rdy) begin
      m_cnt++;
      m_mis = rv && rpc[1:0] != 2'b00;
      m_pc = rv ? (rpc & ~32'd3) : m_pc + 32'd4;
      m_have = 0;
    end
    @(negedge clk_i);
  endtask

  task automatic to_valid();
    for (int i = 0; i < 20 && !m_have; i++) step(1, 0, 0, 0);
    chk("to_valid", 32'(instr_valid_o), 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1;
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
    chk("cnt3", instr_count_o, 3);
    chk("addr_c", imem_addr_o, 32'hC);
    to_valid();
    step(0, 1, 1, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("dly_req", 32'(imem_req_o), 1);
      chk("dly_addr", imem_addr_o, 32'h4);
    end
    step(1, 0, 0, 0);
    chk("dly_instr", instr_o, mem(32'h4));
    chk("dly_pc4", pc_plus4_o, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, i == 2, 32'h200);
      chk("stall_pc", pc_o, 32'h4);
      chk("stall_req", 32'(imem_req_o), 0);
    end
    step(0, 1, 0, 0);
    chk("stall_next", imem_addr_o, 32'h8);
    to_valid();
    step(0, 1, 1, 32'h100);
    chk("redir_addr", imem_addr_o, 32'h100);
    to_valid();
    chk("redir_pc", pc_o, 32'h100);
    step(0, 1, 1, 32'h102);
    chk("mis_addr", imem_addr_o, 32'h100);
    chk("mis_hi", 32'(misalign_o), 1);
    step(0, 0, 0, 0);
    chk("mis_lo", 32'(misalign_o), 0);
    to_valid();
    step(0, 1, 1, 32'hFFFF_FFFC);
    to_valid();
    chk("wrap_pc4", pc_plus4_o, 0);
    step(0, 1, 0, 0);
    chk("wrap_addr", imem_addr_o, 0);
    to_valid();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1 release dut.instr_count_q;
    m_cnt = 32'hFFFF_FFFF;
    step(0, 1, 0, 0);
    chk("cnt_wrap", instr_count_o, 0);
    step(0, 0, 0, 0);
    imem_ack_i = 1;
    #2 rst_i = 0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk_i);
    rst_i = 1;
    step(1, 1, 0, 0);
    chk("post_req", 32'(imem_req_o), 1);
    chk("post_addr", imem_addr_o, 0);
    step(1, 0, 0, 0);
    chk("post_instr", instr_o, mem(0));
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      r = $urandom();
      step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
           r[31] ? r : (r & ~32'd3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage of the single-cycle CPU; sits directly upstream of the main decoder.
- Owns the program counter and issues one request at a time to instruction memory over a req/ack handshake.
- Holds the fetched word in a register and presents it, with its PC, to the decoder and datapath under a valid/ready handshake.
- Advances to PC+4, or to a redirect target supplied by the branch/jump logic when the current instruction is accepted.

Parameters:
- PC_WIDTH, 32, width of PC and instruction memory address.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk_i, input, 1, system clock; all state updates on rising edge.
- rst_i, input, 1, reset; asynchronous, active-low.
- imem_req_o, input-side request to memory: output, 1, fetch request.
- imem_addr_o, output, PC_WIDTH, fetch address; always word-aligned.
- imem_ack_i, input, 1, memory has returned data this cycle.
- imem_rdata_i, input, 32, instruction word; valid when imem_ack_i=1.
- instr_o, output, 32, registered instruction; instr_o[31:26] feeds the decoder opcode.
- instr_valid_o, output, 1, instr_o/pc_o hold a valid instruction.
- instr_ready_i, input, 1, downstream has consumed the instruction this cycle.
- pc_o, output, PC_WIDTH, address of instr_o.
- pc_plus4_o, output, PC_WIDTH, pc_o+4; used for branch/jal link.
- redirect_valid_i, input, 1, next PC comes from redirect_pc_i.
- redirect_pc_i, input, PC_WIDTH, branch/jump target.
- misalign_o, output, 1, one-cycle pulse when a redirect target was not word-aligned.
- instr_count_o, output, 32, count of accepted instructions.

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately) forces:
  - state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_o=0, instr_valid_o=0, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4.
  - misalign_o=0, instr_count_o=0.
- State machine has three states: IDLE, FETCH, VALID.
- IDLE:
  - Entered only from reset; lasts exactly one cycle after rst_i rises.
  - imem_req_o=0; any imem_ack_i is ignored (discards an ack belonging to a request killed by reset).
  - Next state is FETCH.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc; both held stable until ack.
  - On imem_ack_i=1:
    - instr_o<=imem_rdata_i, pc_o<=pc, pc_plus4_o<=pc+4.
    - Next state is VALID.
  - Zero-wait ack (ack in the first FETCH cycle) is legal.
  - No ack: remain in FETCH indefinitely with no timeout.
  - instr_valid_o=0.
  - instr_ready_i and redirect_valid_i are ignored.
- VALID:
  - instr_valid_o=1, imem_req_o=0; instr_o, pc_o and pc_plus4_o held stable.
  - On instr_ready_i=1:
    - pc<=redirect_valid_i ? {redirect_pc_i[PC_WIDTH-1:2],2'b00} : pc+4.
    - instr_count_o<=instr_count_o+1.
    - Next state is FETCH.
  - instr_ready_i=0: hold; redirect_valid_i is ignored.
  - Redirect is sampled only in the accept cycle.
- Misalignment:
  - If redirect_valid_i & instr_ready_i in VALID and redirect_pc_i[1:0]!=0, misalign_o=1 for the following cycle only.
  - The target is truncated to word alignment as described above.
- Arithmetic:
  - pc+4 is modulo 2^PC_WIDTH: 32'hFFFF_FFFC -> 32'h0000_0000, with no flag.
  - instr_count_o wraps 32'hFFFF_FFFF -> 0.
- Throughput and latency:
  - Minimum of 2 cycles per instruction (FETCH with zero-wait ack, then VALID with ready=1).
  - First imem_req_o is asserted 1 cycle after rst_i deasserts.
- imem_ack_i outside FETCH is ignored.
- Reset mid-operation aborts any outstanding fetch; the instruction presented in VALID is dropped without counting.

Test Plan:
- Reset release, zero-wait memory, ready tied 1:
  - imem_addr_o sequence 0x0, 0x4, 0x8 on FETCH cycles 2 clocks apart.
  - instr_valid_o toggles 0/1.
  - instr_count_o=3 after third accept.
- Memory ack delayed 3 cycles at pc=0x4:
  - imem_req_o stays 1 and imem_addr_o stays 0x4 for 3 cycles.
  - instr_o=imem_rdata_i captured on the ack edge.
  - pc_plus4_o=0x8.
- Downstream stall (ready=0 for 5 cycles in VALID):
  - instr_o/pc_o unchanged and imem_req_o=0 throughout.
  - redirect_valid_i pulsed during the stall is ignored; next fetch is pc+4.
- Redirect on accept, redirect_pc_i=0x100: next imem_addr_o=0x100, pc_o=0x100 after ack. With redirect_pc_i=0x102: imem_addr_o=0x100 and misalign_o high for exactly one cycle.
- Wrap: redirect to 0xFFFFFFFC, accept without redirect -> next fetch address 0x00000000. Preload instr_count_o to 0xFFFFFFFF (force) and accept -> 0.
- Assert rst_i=0 mid-FETCH with ack pending:
  - imem_req_o drops asynchronously and all outputs take their reset values.
  - An ack in the IDLE cycle after release is not captured.
  - The first fetch is at RESET_PC.
